// File: rtl/edge_sampler.sv
// Turns an asynchronous comparator level into a one-cycle pulse per qualifying edge.
// Capture happens on the falling clock edge so half-period pulses are still seen.
module edge_sampler #(
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int MODE_RISE = 0;
    localparam int MODE_FALL = 1;

    logic cap;
    logic lvl;
    logic prev;
    logic hit;

    // Falling-edge capture; reset is honoured at the falling edge too.
    always_ff @(negedge clk) begin
        if (rst) begin
            cap <= 1'b0;
        end else begin
            cap <= in;
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign lvl = cap;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                end else begin
                    sync[0] <= cap;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign lvl = sync[SYNC_STAGES-1];
        end
    endgenerate

    // Any mode value other than rise/fall detects both edges.
    always_comb begin
        hit = 1'b0;
        case (EDGE_MODE)
            MODE_RISE: hit = lvl & ~prev;
            MODE_FALL: hit = ~lvl & prev;
            default:   hit = lvl ^ prev;
        endcase
    end

    // out is a pulse with no handshake: high for exactly one cycle per detected edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            out  <= 1'b0;
        end else begin
            prev <= lvl;
            out  <= hit;
        end
    end

endmodule

// File: tb/tb_edge_sampler.sv
// Scoreboard bench for edge_sampler: four instances (rise, fall, both, rise with two sync stages)
// share one input; expected pulse cycles are queued by the driver and checked by a monitor.
module tb_edge_sampler;

    logic clk;
    logic rst;
    logic in;
    logic [3:0] outs;

    int cyc;
    int checks;
    int errors;
    logic cur;

    // Expected pulse cycle numbers per instance, in issue order.
    logic [31:0] exp_q[4][$];
    string names[4];

    edge_sampler #(.EDGE_MODE(0), .SYNC_STAGES(0)) u_rise (.clk(clk), .rst(rst), .in(in), .out(outs[0]));
    edge_sampler #(.EDGE_MODE(1), .SYNC_STAGES(0)) u_fall (.clk(clk), .rst(rst), .in(in), .out(outs[1]));
    edge_sampler #(.EDGE_MODE(2), .SYNC_STAGES(0)) u_both (.clk(clk), .rst(rst), .in(in), .out(outs[2]));
    edge_sampler #(.EDGE_MODE(0), .SYNC_STAGES(2)) u_sync (.clk(clk), .rst(rst), .in(in), .out(outs[3]));

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: one sample per cycle, just after the rising edge.
    always begin
        logic exp_bit;
        @(posedge clk);
        #1;
        if (cyc >= 1) begin
            for (int i = 0; i < 4; i++) begin
                exp_bit = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
                if (exp_bit) void'(exp_q[i].pop_front());
                checks = checks + 1;
                if (outs[i] !== exp_bit) begin
                    errors = errors + 1;
                    $display("FAIL %s cycle %0d out=%b expected=%b", names[i], cyc, outs[i], exp_bit);
                end
            end
        end
    end

    // Driver tasks; every drive happens 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // A level held across the next falling edge is captured there and pulses one
    // cycle later without sync stages, three cycles later with two.
    task automatic push_rise(input int base);
        exp_q[0].push_back(base + 1);
        exp_q[2].push_back(base + 1);
        exp_q[3].push_back(base + 3);
    endtask

    task automatic push_fall(input int base);
        exp_q[1].push_back(base + 1);
        exp_q[2].push_back(base + 1);
    endtask

    task automatic set_in(input logic v);
        if (v && !cur) push_rise(cyc);
        if (!v && cur) push_fall(cyc);
        in  = v;
        cur = v;
    endtask

    initial begin
        int c0;
        names[0] = "rise_s0";
        names[1] = "fall_s0";
        names[2] = "both_s0";
        names[3] = "rise_s2";
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in  = 1'b0;
        cur = 1'b0;

        // Reset held four cycles with in low.
        tick(4);
        rst = 1'b0;
        tick($urandom_range(10, 5));

        // Pulse train: high after each rising edge, low after each falling edge.
        c0 = cyc;
        push_rise(c0);
        for (int k = 0; k < 30; k++) begin
            in = 1'b1;
            @(negedge clk);
            #2;
            in = 1'b0;
            tick(1);
        end
        cur = 1'b1;
        set_in(1'b0);

        // Idle.
        tick(50);

        // Level stimulus: rise, fall, rise.
        set_in(1'b1);
        tick(10);
        set_in(1'b0);
        tick(10);
        set_in(1'b1);
        tick(10);

        // Low glitch entirely between falling edges is invisible.
        in = 1'b0;
        #2;
        in = 1'b1;
        tick(5);
        set_in(1'b0);
        tick(5);

        // Toggle every cycle: both-edge instance pulses every cycle.
        for (int k = 0; k < 6; k++) begin
            set_in(~cur);
            tick(1);
        end
        tick(6);

        // Reset right after in is captured high: the pending pulse is dropped.
        in = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        cur = 1'b0;
        set_in(1'b1);
        tick(10);
        set_in(1'b0);
        tick(10);

        for (int i = 0; i < 4; i++) begin
            checks = checks + 1;
            if (exp_q[i].size() != 0) begin
                errors = errors + 1;
                $display("FAIL %s pending pulses=%0d expected=0", names[i], exp_q[i].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_sampler.md
Name: edge_sampler

Overview:
- Converts an asynchronous, level-type comparator output into a single-cycle, clock-synchronous pulse, one per qualifying edge of the comparator output.
- The comparator output can be high for as little as half a clock period. It is therefore captured on the falling clock edge, then edge-detected in the rising-edge domain.
- Sits between the analog comparator and the SAR/counter control logic in the ADC digital back end.

Parameters:
- EDGE_MODE, 0, edge that produces a pulse: 0 = rising (0->1) of the captured input, 1 = falling (1->0), 2 = both.
- SYNC_STAGES, 0, number of extra rising-edge synchronizer flops between the falling-edge capture flop and the edge detector. Each stage adds exactly one clock of latency.

Ports:
- clk  input  1  system clock; all logic derives from this single clock.
- rst  input  1  reset, synchronous, active-high.
- in   input  1  asynchronous comparator output; may toggle at any time; minimum high/low width is half a clk period.
- out  output 1  registered single-cycle pulse marking a qualifying edge of in.

Behaviour:
- Single clock domain; one clock (clk); reset (rst) is synchronous and active-high.
- Capture stage:
  - cap is sampled from in on every falling edge of clk.
  - When rst is high at that falling edge, cap loads 0 instead.
- Sync stages (SYNC_STAGES >= 1 only):
  - Chain of SYNC_STAGES flops on the rising edge of clk, fed from cap.
  - The chain output is called lvl. With SYNC_STAGES = 0, lvl = cap.
- Edge detector, on the rising edge of clk:
  - prev <= lvl.
  - out <= rise | fall | both, according to EDGE_MODE, where rise = lvl & ~prev, fall = ~lvl & prev, both = lvl ^ prev.
  - out is a flop output and never combinational from in.
- Reset, on any rising edge with rst = 1: out, prev and all sync flops clear to 0; cap clears at the falling edge while rst is high.
  - After release, history is 0. An in that is already high at the first capture counts as a rising edge and produces one pulse.
- Latency (SYNC_STAGES = 0): in rises after rising edge R1 and is still high at the next falling edge F1 -> out is 1 for exactly the period R2..R3, and 0 again from R3.
  - At R1 and R2, out reads 0; at R3, it reads 1 (pre-edge value). Each sync stage shifts this by one clock.
- Pulse width: out is high for exactly one clk period per detected edge; never two consecutive cycles in modes 0 and 1.
- Input pulse train: if in goes high after every rising edge and low after every falling edge, it is high at every falling-edge sample. cap is then constantly 1 -> mode 0 gives exactly one pulse, then out stays 0 for the rest of the train.
- Glitches narrower than half a period that fall between falling edges are not seen. This is required behaviour, not an error.
- Mode 2, level toggling each capture: out high on every cycle a change is seen.
- Reset mid-operation: a pending pulse is dropped. out is 0 on the cycle after the reset rising edge and stays 0 while rst is held.
- X/Z on in is not propagated after reset: cap holds the value sampled, and the bench drives in to 0 or 1.

Test Plan:
- Reset: hold rst = 1 for 4 cycles with in = 0 -> out = 0 at every rising edge during and after reset, until in rises.
- Basic rise, EDGE_MODE = 0: in = 0 for 5-10 random cycles after reset; then 30x (in = 1 just after the rising edge, in = 0 just after the falling edge) -> out = 0, 0, 1 at the first three rising edges after the first in rise, then 0 for all remaining cycles.
- Idle: in held 0 for 50 cycles -> out = 0 throughout.
- Level input, EDGE_MODE = 0: in 0->1 held 10 cycles, ->0 for 10, ->1 again -> exactly two single-cycle pulses, each 2 rising edges after its rise.
- Falling / both modes: same level stimulus -> mode 1 gives one pulse 2 rising edges after the fall; mode 2 gives three pulses.
- Reset mid-pulse plus SYNC_STAGES = 2: assert rst on the cycle in is captured high -> no pulse. Release with in high -> one pulse, latency 2 extra cycles versus SYNC_STAGES = 0.
